ctrl_pipe_hazard: RTL and testbench
===================================

Name: ctrl_pipe_hazard

Overview:
- Consumer end of the main control decoder: receives the ID-stage control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control pipeline registers.
- Owns load-use hazard detection. On a hazard it inserts a bubble and stalls PC and IF/ID.
- Owns branch-taken flushing. The branch is resolved in MEM.
- Sits beside the datapath pipeline registers. It drives the per-stage control taps and the PC/IF/ID write enables.

Parameters:
REG_W, 5, register specifier width
ALUOP_W, 2, width of aluop field

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_regdst  in  1  decoder output, ID stage
id_branch  in  1  decoder output
id_memread  in  1  decoder output
id_memtoreg  in  1  decoder output
id_aluop  in  ALUOP_W  decoder output
id_memwrite  in  1  decoder output
id_alusrc  in  1  decoder output
id_regwrite  in  1  decoder output
id_rs  in  REG_W  instr[25:21] in ID
id_rt  in  REG_W  instr[20:16] in ID
mem_zero  in  1  ALU zero flag registered in EX/MEM
ex_regdst, ex_alusrc  out  1  EX-stage controls
ex_aluop  out  ALUOP_W  EX-stage ALU op
mem_branch, mem_memread, mem_memwrite  out  1  MEM-stage controls
wb_memtoreg, wb_regwrite  out  1  WB-stage controls
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
if_flush  out  1  IF/ID clear request

Behaviour:
- Reset (async, rst=1): every pipeline control register and the internal ex_rt register clear to 0.
  - Hence all stage outputs are 0, pc_write=1, ifid_write=1, if_flush=0.
  - Reset asserted mid-operation discards all in-flight controls immediately, without waiting for a clock edge.
- X sanitising at ID/EX capture:
  - id_regdst is registered as 0 when id_regwrite=0.
  - id_memtoreg is registered as 0 when id_regwrite=0.
  - All other fields are registered as received.
- taken = mem_branch & mem_zero (combinational).
- stall = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & !taken.
  - Comparison is conservative: non-R/I formats (e.g. jump) may stall spuriously. This is accepted.
- Combinational outputs:
  - pc_write = !stall
  - ifid_write = !stall
  - if_flush = taken
- Per rising clk, priority order flush > stall > normal:
  - taken=1: ID/EX <= 0 and EX/MEM <= 0. MEM/WB <= MEM-stage wb fields (normal).
  - stall=1: ID/EX <= 0 (bubble), ex_rt <= 0. EX/MEM and MEM/WB advance normally.
  - Otherwise: ID/EX <= sanitised ID bundle and ex_rt <= id_rt. EX/MEM <= EX bundle. MEM/WB <= MEM wb fields.
- Latency: an ID control bit appears on the ex_* outputs 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- A stall lasts exactly 1 cycle per load, because the bubble clears ex_memread.
- Back-to-back loads with dependencies each produce one bubble.
- A branch in ID while a load-use hazard is pending: the stall applies first, then the branch proceeds.
- Simultaneous taken and stall: stall is masked, pc_write=1, and both younger stages are flushed.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs stall_cnt and flush_cnt, each 16-bit.
  - stall_cnt increments on every clk with stall=1.
  - flush_cnt increments on every clk with taken=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: assert rst with random inputs -> all stage outputs 0, pc_write=1, ifid_write=1, if_flush=0, without any clock edge.
- R-type pass-through: drive the R-type bundle (regdst=1, aluop=2'b10, regwrite=1) for 1 cycle, then zeros -> ex_aluop=2'b10 at +1, wb_regwrite=1 at +3, then 0.
- Load-use: load (memread=1, id_rt=5), then next ID has id_rs=5 -> pc_write=0 and ifid_write=0 for 1 cycle, all ex_* = 0 the following cycle, then normal flow resumes.
- No stall on $0: load with id_rt=0 followed by an instruction with id_rs=0 -> pc_write stays 1.
- Branch taken: beq bundle (branch=1, aluop=2'b01), mem_zero=1 when mem_branch=1 -> if_flush=1 that cycle; next cycle ex_* and mem_* are all 0.
- Flush over stall: force taken and a load-use match in the same cycle -> pc_write=1, if_flush=1, ex_rt cleared; with HAZARD_PERF_EN, flush_cnt +1 and stall_cnt unchanged.

Source files
------------

// File: rtl/ctrl_pipe_hazard_if.sv
// Control-pipe bundle between the ID decoder/datapath and ctrl_pipe_hazard.
// Slave side is the hazard/control block; master side drives ID fields.
interface ctrl_pipe_hazard_if #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
);
    logic               id_regdst;
    logic               id_branch;
    logic               id_memread;
    logic               id_memtoreg;
    logic [ALUOP_W-1:0] id_aluop;
    logic               id_memwrite;
    logic               id_alusrc;
    logic               id_regwrite;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic               mem_zero;

    logic               ex_regdst;
    logic               ex_alusrc;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               mem_branch;
    logic               mem_memread;
    logic               mem_memwrite;
    logic               wb_memtoreg;
    logic               wb_regwrite;
    logic               pc_write;
    logic               ifid_write;
    logic               if_flush;

    modport slave (
        input  id_regdst, id_branch, id_memread, id_memtoreg,
        input  id_aluop, id_memwrite, id_alusrc, id_regwrite,
        input  id_rs, id_rt, mem_zero,
        output ex_regdst, ex_alusrc, ex_aluop,
        output mem_branch, mem_memread, mem_memwrite,
        output wb_memtoreg, wb_regwrite,
        output pc_write, ifid_write, if_flush
    );

    modport master (
        output id_regdst, id_branch, id_memread, id_memtoreg,
        output id_aluop, id_memwrite, id_alusrc, id_regwrite,
        output id_rs, id_rt, mem_zero,
        input  ex_regdst, ex_alusrc, ex_aluop,
        input  mem_branch, mem_memread, mem_memwrite,
        input  wb_memtoreg, wb_regwrite,
        input  pc_write, ifid_write, if_flush
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall and MEM-resolved
// branch flush. Optional macro HAZARD_PERF_EN adds stall_cnt/flush_cnt counters.
module ctrl_pipe_hazard #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef HAZARD_PERF_EN
    output logic [15:0]          stall_cnt,
    output logic [15:0]          flush_cnt,
`endif
    ctrl_pipe_hazard_if.slave    bus
);

    typedef struct packed {
        logic               regdst;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               regwrite;
    } idex_t;

    typedef struct packed {
        logic branch;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } exmem_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } memwb_t;

    idex_t            idex_q, idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;

    logic taken;
    logic rt_hit;
    logic stall;

    // Hazard detection: branch taken in MEM masks any load-use stall.
    always_comb begin
        taken  = exmem_q.branch & bus.mem_zero;
        rt_hit = (ex_rt_q == bus.id_rs) | (ex_rt_q == bus.id_rt);
        stall  = idex_q.memread & (ex_rt_q != '0) & rt_hit & ~taken;
    end

    // Next-state for the three control registers: flush > stall > advance.
    always_comb begin
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.regwrite = exmem_q.regwrite;

        exmem_d.branch   = idex_q.branch;
        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.memtoreg = idex_q.memtoreg;
        exmem_d.regwrite = idex_q.regwrite;

        idex_d.regdst    = bus.id_regdst & bus.id_regwrite;
        idex_d.alusrc    = bus.id_alusrc;
        idex_d.aluop     = bus.id_aluop;
        idex_d.branch    = bus.id_branch;
        idex_d.memread   = bus.id_memread;
        idex_d.memwrite  = bus.id_memwrite;
        idex_d.memtoreg  = bus.id_memtoreg & bus.id_regwrite;
        idex_d.regwrite  = bus.id_regwrite;
        ex_rt_d          = bus.id_rt;

        if (taken) begin
            idex_d  = '0;
            ex_rt_d = '0;
            exmem_d = '0;
        end else if (stall) begin
            idex_d  = '0;
            ex_rt_d = '0;
        end
    end

    // Pipeline control registers, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= '0;
            ex_rt_q <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            ex_rt_q <= ex_rt_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.ex_regdst    = idex_q.regdst;
    assign bus.ex_alusrc    = idex_q.alusrc;
    assign bus.ex_aluop     = idex_q.aluop;
    assign bus.mem_branch   = exmem_q.branch;
    assign bus.mem_memread  = exmem_q.memread;
    assign bus.mem_memwrite = exmem_q.memwrite;
    assign bus.wb_memtoreg  = memwb_q.memtoreg;
    assign bus.wb_regwrite  = memwb_q.regwrite;
    assign bus.pc_write     = ~stall;
    assign bus.ifid_write   = ~stall;
    assign bus.if_flush     = taken;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (taken && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: instruction-slot model plus directed literal checks.
// Honours HAZARD_PERF_EN when defined.
module tb_ctrl_pipe_hazard;

    typedef struct packed {
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic [1:0] aluop;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [4:0] rs;
        logic [4:0] rt;
    } instr_t;

    logic clk;
    logic rst;

    ctrl_pipe_hazard_if #(.REG_W(5), .ALUOP_W(2)) bus ();

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    ctrl_pipe_hazard #(.REG_W(5), .ALUOP_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef HAZARD_PERF_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the instruction occupying each stage (bubble = all-zero record).
    instr_t s_ex, s_mem, s_wb;
    instr_t cur;
    logic   cur_zero;
    int     m_stalls, m_flushes;

    function automatic instr_t mk(logic regdst, logic branch, logic memread,
                                  logic memtoreg, logic [1:0] aluop,
                                  logic memwrite, logic alusrc,
                                  logic regwrite, int rs, int rt);
        instr_t i;
        i.regdst   = regdst;
        i.branch   = branch;
        i.memread  = memread;
        i.memtoreg = memtoreg;
        i.aluop    = aluop;
        i.memwrite = memwrite;
        i.alusrc   = alusrc;
        i.regwrite = regwrite;
        i.rs       = 5'(rs);
        i.rt       = 5'(rt);
        return i;
    endfunction

    function automatic logic m_taken();
        return s_mem.branch && cur_zero;
    endfunction

    function automatic logic m_stall();
        logic hit;
        hit = (s_ex.rt == cur.rs) || (s_ex.rt == cur.rt);
        return s_ex.memread && (s_ex.rt != 0) && hit && !m_taken();
    endfunction

    function automatic logic [12:0] exp_vec();
        logic st;
        st = m_stall();
        return {s_ex.regdst, s_ex.alusrc, s_ex.aluop,
                s_mem.branch, s_mem.memread, s_mem.memwrite,
                s_wb.memtoreg, s_wb.regwrite,
                !st, !st, m_taken()};
    endfunction

    function automatic logic [12:0] act_vec();
        return {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop,
                bus.mem_branch, bus.mem_memread, bus.mem_memwrite,
                bus.wb_memtoreg, bus.wb_regwrite,
                bus.pc_write, bus.ifid_write, bus.if_flush};
    endfunction

    task automatic model_reset();
        s_ex      = '0;
        s_mem     = '0;
        s_wb      = '0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    task automatic model_clock();
        instr_t captured;
        logic   tk, st;
        tk = m_taken();
        st = m_stall();
        captured = cur;
        if (!cur.regwrite) begin
            captured.regdst   = 1'b0;
            captured.memtoreg = 1'b0;
        end
        if (st && m_stalls < 65535) m_stalls++;
        if (tk && m_flushes < 65535) m_flushes++;
        s_wb = s_mem;
        if (tk) begin
            s_mem = '0;
            s_ex  = '0;
        end else if (st) begin
            s_mem = s_ex;
            s_ex  = '0;
        end else begin
            s_mem = s_ex;
            s_ex  = captured;
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(string name);
        logic [12:0] a, e;
        a = act_vec();
        e = exp_vec();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, a, e);
        end
`ifdef HAZARD_PERF_EN
        chk({name, "_stall_cnt"}, int'(stall_cnt), m_stalls);
        chk({name, "_flush_cnt"}, int'(flush_cnt), m_flushes);
`endif
    endtask

    task automatic drive(instr_t i, logic z);
        cur              = i;
        cur_zero         = z;
        bus.id_regdst    = i.regdst;
        bus.id_branch    = i.branch;
        bus.id_memread   = i.memread;
        bus.id_memtoreg  = i.memtoreg;
        bus.id_aluop     = i.aluop;
        bus.id_memwrite  = i.memwrite;
        bus.id_alusrc    = i.alusrc;
        bus.id_regwrite  = i.regwrite;
        bus.id_rs        = i.rs;
        bus.id_rt        = i.rt;
        bus.mem_zero     = z;
    endtask

    task automatic apply(instr_t i, logic z);
        @(negedge clk);
        drive(i, z);
        #1;
        compare("cycle");
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    function automatic instr_t rnd_instr();
        instr_t i;
        i          = instr_t'($urandom);
        i.memread  = ($urandom_range(0, 1) == 0);
        i.branch   = ($urandom_range(0, 3) == 0);
        i.rs       = 5'($urandom_range(0, 3));
        i.rt       = 5'($urandom_range(0, 3));
        return i;
    endfunction

    instr_t zero_i;
    instr_t rtype;
    instr_t load5;
    instr_t use5;
    instr_t beq;
`ifdef HAZARD_PERF_EN
    int sc0, fc0;
`endif

    initial begin
        zero_i = '0;
        rst    = 1'b0;
        drive(rnd_instr(), 1'($urandom));
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("reset_pc_write", int'(bus.pc_write), 1);
        chk("reset_ifid_write", int'(bus.ifid_write), 1);
        chk("reset_if_flush", int'(bus.if_flush), 0);
        chk("reset_ex_aluop", int'(bus.ex_aluop), 0);
        chk("reset_wb_regwrite", int'(bus.wb_regwrite), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        apply(zero_i, 1'b0); tick();
        apply(zero_i, 1'b0); tick();

        // R-type pass-through
        rtype = mk(1, 0, 0, 0, 2'b10, 0, 0, 1, 1, 2);
        apply(rtype, 1'b0); tick();
        chk("rtype_ex_aluop", int'(bus.ex_aluop), 2);
        chk("rtype_ex_regdst", int'(bus.ex_regdst), 1);
        apply(zero_i, 1'b0); tick();
        apply(zero_i, 1'b0); tick();
        chk("rtype_wb_regwrite", int'(bus.wb_regwrite), 1);
        apply(zero_i, 1'b0); tick();
        chk("rtype_wb_regwrite_off", int'(bus.wb_regwrite), 0);

        // Load-use on $5
        load5 = mk(0, 0, 1, 1, 2'b00, 0, 1, 1, 0, 5);
        use5  = mk(1, 0, 0, 0, 2'b10, 0, 0, 1, 5, 7);
        apply(load5, 1'b0); tick();
        apply(use5, 1'b0);
        chk("lu_pc_write", int'(bus.pc_write), 0);
        chk("lu_ifid_write", int'(bus.ifid_write), 0);
        tick();
        chk("lu_bubble_regdst", int'(bus.ex_regdst), 0);
        chk("lu_bubble_aluop", int'(bus.ex_aluop), 0);
        apply(use5, 1'b0);
        chk("lu_resume_pc_write", int'(bus.pc_write), 1);
        tick();
        chk("lu_resume_aluop", int'(bus.ex_aluop), 2);

        // No stall on $0
        apply(mk(0, 0, 1, 1, 2'b00, 0, 1, 1, 0, 0), 1'b0); tick();
        apply(mk(1, 0, 0, 0, 2'b10, 0, 0, 1, 0, 0), 1'b0);
        chk("r0_pc_write", int'(bus.pc_write), 1);
        tick();

        // Branch taken
        beq = mk(0, 1, 0, 0, 2'b01, 0, 0, 0, 1, 2);
        apply(beq, 1'b0); tick();
        apply(rtype, 1'b0); tick();
        apply(rtype, 1'b1);
        chk("br_if_flush", int'(bus.if_flush), 1);
        tick();
        chk("br_ex_aluop", int'(bus.ex_aluop), 0);
        chk("br_mem_branch", int'(bus.mem_branch), 0);

        // Flush over stall
        apply(zero_i, 1'b0); tick();
        apply(mk(0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0), 1'b0); tick();
        apply(mk(0, 0, 1, 1, 2'b00, 0, 1, 1, 0, 6), 1'b0); tick();
`ifdef HAZARD_PERF_EN
        sc0 = int'(stall_cnt);
        fc0 = int'(flush_cnt);
`endif
        apply(mk(1, 0, 0, 0, 2'b10, 0, 0, 1, 6, 1), 1'b1);
        chk("fs_pc_write", int'(bus.pc_write), 1);
        chk("fs_if_flush", int'(bus.if_flush), 1);
        tick();
        chk("fs_mem_memread", int'(bus.mem_memread), 0);
`ifdef HAZARD_PERF_EN
        chk("fs_flush_cnt", int'(flush_cnt), fc0 + 1);
        chk("fs_stall_cnt", int'(stall_cnt), sc0);
`endif
        apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 6, 6), 1'b0);
        chk("fs_ex_rt_cleared", int'(bus.pc_write), 1);
        tick();

        // Randomised traffic with one mid-operation reset
        for (int n = 0; n < 600; n++) begin
            apply(rnd_instr(), 1'($urandom));
            if (n == 300) begin
                #1 rst = 1'b1;
                #1;
                model_reset();
                compare("async_reset");
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
